// File: rtl/set_assoc_cache_if.sv
// rtl/set_assoc_cache_if.sv - CPU load/store and data-memory handshake bundle for set_assoc_cache
interface set_assoc_cache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_req_i;
    logic                  cpu_we_i;
    logic [ADDR_WIDTH-1:0] cpu_addr_i;
    logic [DATA_WIDTH-1:0] cpu_wdata_i;
    logic                  cpu_ready_o;
    logic                  cpu_rvalid_o;
    logic [DATA_WIDTH-1:0] cpu_rdata_o;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_ack_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_ack_i, mem_rdata_i,
        output cpu_ready_o, cpu_rvalid_o, cpu_rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_ack_i, mem_rdata_i,
        input  cpu_ready_o, cpu_rvalid_o, cpu_rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - N-way write-through, no-write-allocate data cache with true-LRU; CACHE_STATS_EN adds hit/miss/write counters
module set_assoc_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WAYS       = 4,
    parameter int SETS       = 8
) (
    input  logic clk,
    input  logic rst,
    set_assoc_cache_if.slave bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] stat_hits_o,
    output logic [31:0] stat_misses_o,
    output logic [31:0] stat_writes_o
`endif
);
    localparam int IDX_W = $clog2(SETS);
    localparam int LRU_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;
    typedef logic [WAYS-1:0][LRU_W-1:0] age_row_t;

    state_t                state;
    logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];
    logic [WAYS-1:0]       valid_q [SETS];
    age_row_t              age_q   [SETS];
    logic [IDX_W-1:0]      lat_idx;
    logic [TAG_W-1:0]      lat_tag;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic [LRU_W-1:0] hit_way;
    logic             vic_found;
    logic [LRU_W-1:0] vic_way;
    logic             accept;

    assign idx             = bus.cpu_addr_i[IDX_W+1:2];
    assign tag             = bus.cpu_addr_i[ADDR_WIDTH-1:IDX_W+2];
    assign bus.cpu_ready_o = (state == IDLE) && !rst;
    assign accept          = bus.cpu_req_i && (state == IDLE);

    // Most recent use gets age 0; everything younger than the touched way ages by one.
    function automatic age_row_t touch(input age_row_t row, input logic [LRU_W-1:0] h);
        age_row_t r;
        r = row;
        for (int w = 0; w < WAYS; w++)
            if (row[w] < row[h]) r[w] = row[w] + 1'b1;
        r[h] = '0;
        return r;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = LRU_W'(w);
            end
    end

    // Victim selection uses the latched miss index; descending scan leaves the lowest invalid way.
    always_comb begin
        vic_found = 1'b0;
        vic_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_q[lat_idx][w]) begin
                vic_found = 1'b1;
                vic_way   = LRU_W'(w);
            end
        if (!vic_found)
            for (int w = 0; w < WAYS; w++)
                if (age_q[lat_idx][w] == LRU_W'(WAYS - 1)) vic_way = LRU_W'(w);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            lat_idx          <= '0;
            lat_tag          <= '0;
            bus.cpu_rvalid_o <= 1'b0;
            bus.cpu_rdata_o  <= '0;
            bus.mem_req_o    <= 1'b0;
            bus.mem_we_o     <= 1'b0;
            bus.mem_addr_o   <= '0;
            bus.mem_wdata_o  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= LRU_W'(w);
            end
        end else begin
            bus.cpu_rvalid_o <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    bus.mem_addr_o <= {bus.cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    if (!bus.cpu_we_i) begin
                        if (hit) begin
                            bus.cpu_rdata_o  <= data_q[idx][hit_way];
                            bus.cpu_rvalid_o <= 1'b1;
                            age_q[idx]       <= touch(age_q[idx], hit_way);
                        end else begin
                            lat_idx       <= idx;
                            lat_tag       <= tag;
                            bus.mem_req_o <= 1'b1;
                            bus.mem_we_o  <= 1'b0;
                            state         <= RD_MISS;
                        end
                    end else begin
                        if (hit) begin
                            data_q[idx][hit_way] <= bus.cpu_wdata_i;
                            age_q[idx]           <= touch(age_q[idx], hit_way);
                        end
                        bus.mem_req_o   <= 1'b1;
                        bus.mem_we_o    <= 1'b1;
                        bus.mem_wdata_o <= bus.cpu_wdata_i;
                        state           <= WR_THRU;
                    end
                end
                RD_MISS: if (bus.mem_ack_i) begin
                    tag_q[lat_idx][vic_way]   <= lat_tag;
                    data_q[lat_idx][vic_way]  <= bus.mem_rdata_i;
                    valid_q[lat_idx][vic_way] <= 1'b1;
                    age_q[lat_idx]            <= touch(age_q[lat_idx], vic_way);
                    bus.cpu_rdata_o           <= bus.mem_rdata_i;
                    bus.cpu_rvalid_o          <= 1'b1;
                    bus.mem_req_o             <= 1'b0;
                    state                     <= IDLE;
                end
                WR_THRU: if (bus.mem_ack_i) begin
                    bus.mem_req_o <= 1'b0;
                    bus.mem_we_o  <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt, write_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            write_cnt <= '0;
        end else if (accept) begin
            if (bus.cpu_we_i) begin
                if (write_cnt != '1) write_cnt <= write_cnt + 32'd1;
            end else if (hit) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    assign stat_hits_o   = hit_cnt;
    assign stat_misses_o = miss_cnt;
    assign stat_writes_o = write_cnt;
`endif
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb/tb_set_assoc_cache.sv - randomized and directed checks of set_assoc_cache against a recency-list model
module tb_set_assoc_cache;
    localparam int AW = 32, DW = 32, WAYS = 4, SETS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    set_assoc_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses, stat_writes;
`endif

    set_assoc_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAYS(WAYS), .SETS(SETS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits_o(stat_hits),
        .stat_misses_o(stat_misses),
        .stat_writes_o(stat_writes)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Per set: resident word addresses ordered most-recent first.
    logic [31:0] res_addr [SETS][WAYS];
    int          res_cnt  [SETS];
    logic [31:0] mem_model [logic [31:0]];
    int exp_hits = 0, exp_misses = 0, exp_writes = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int set_of(input logic [31:0] wa);
        return int'(wa[4:2]);
    endfunction

    function automatic int find(input logic [31:0] wa);
        int s = set_of(wa);
        for (int i = 0; i < res_cnt[s]; i++)
            if (res_addr[s][i] == wa) return i;
        return -1;
    endfunction

    function automatic void promote(input logic [31:0] wa, input int pos);
        int s = set_of(wa);
        for (int i = pos; i > 0; i--) res_addr[s][i] = res_addr[s][i-1];
        res_addr[s][0] = wa;
    endfunction

    function automatic void insert(input logic [31:0] wa);
        int s = set_of(wa);
        if (res_cnt[s] < WAYS) res_cnt[s]++;
        for (int i = res_cnt[s] - 1; i > 0; i--) res_addr[s][i] = res_addr[s][i-1];
        res_addr[s][0] = wa;
    endfunction

    function automatic void clear_model();
        for (int s = 0; s < SETS; s++) res_cnt[s] = 0;
        exp_hits = 0;
        exp_misses = 0;
        exp_writes = 0;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] wa);
        if (mem_model.exists(wa)) return mem_model[wa];
        return {wa[15:0], ~wa[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // Entered at the negedge right after the request was accepted.
    task automatic serve_mem(input logic [31:0] wa, input bit is_wr, input logic [31:0] wd,
                             input int lat, input string tag);
        check({tag, "_req"}, bus.mem_req_o, 1);
        check({tag, "_we"}, bus.mem_we_o, is_wr);
        check({tag, "_addr"}, bus.mem_addr_o, wa);
        if (is_wr) check({tag, "_wdata"}, bus.mem_wdata_o, wd);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, bus.mem_req_o, 1);
            check({tag, "_norv"}, bus.cpu_rvalid_o, 0);
        end
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = is_wr ? $urandom : mem_read(wa);
        if (is_wr) mem_model[wa] = wd;
        @(negedge clk);
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        check({tag, "_drop"}, bus.mem_req_o, 0);
    endtask

    task automatic do_load(input logic [31:0] addr, input int lat, input string tag);
        logic [31:0] wa   = addr & ~32'h3;
        int          pos  = find(wa);
        logic [31:0] expd = mem_read(wa);
        @(negedge clk);
        check({tag, "_ready"}, bus.cpu_ready_o, 1);
        check({tag, "_rv_idle"}, bus.cpu_rvalid_o, 0);
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = $urandom;
        bus.mem_ack_i   = ($urandom_range(0, 7) == 0);
        @(negedge clk);
        bus.cpu_req_i = 1'b0;
        bus.mem_ack_i = 1'b0;
        if (pos >= 0) begin
            check({tag, "_hit_rv"}, bus.cpu_rvalid_o, 1);
            check({tag, "_hit_data"}, bus.cpu_rdata_o, expd);
            check({tag, "_hit_noreq"}, bus.mem_req_o, 0);
            promote(wa, pos);
            exp_hits++;
        end else begin
            check({tag, "_miss_rv"}, bus.cpu_rvalid_o, 0);
            serve_mem(wa, 1'b0, '0, lat, tag);
            check({tag, "_miss_rv"}, bus.cpu_rvalid_o, 1);
            check({tag, "_miss_data"}, bus.cpu_rdata_o, expd);
            insert(wa);
            exp_misses++;
        end
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input int lat,
                            input string tag);
        logic [31:0] wa  = addr & ~32'h3;
        int          pos = find(wa);
        @(negedge clk);
        check({tag, "_ready"}, bus.cpu_ready_o, 1);
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = 1'b1;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = data;
        @(negedge clk);
        bus.cpu_req_i = 1'b0;
        bus.cpu_we_i  = 1'b0;
        check({tag, "_norv"}, bus.cpu_rvalid_o, 0);
        check({tag, "_busy"}, bus.cpu_ready_o, 0);
        if (pos >= 0) promote(wa, pos);
        exp_writes++;
        serve_mem(wa, 1'b1, data, lat, tag);
        check({tag, "_norv_end"}, bus.cpu_rvalid_o, 0);
    endtask

    task automatic reset_mid_miss(input logic [31:0] addr);
        @(negedge clk);
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = addr;
        @(negedge clk);
        bus.cpu_req_i = 1'b0;
        check("rstmiss_req", bus.mem_req_o, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmiss_req_off", bus.mem_req_o, 0);
        check("rstmiss_norv", bus.cpu_rvalid_o, 0);
        check("rstmiss_notready", bus.cpu_ready_o, 0);
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        check("rstmiss_norv2", bus.cpu_rvalid_o, 0);
        check("rstmiss_ready", bus.cpu_ready_o, 1);
    endtask

    task automatic back_to_back(input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3);
        logic [31:0] addrs [4];
        addrs[0] = a0; addrs[1] = a1; addrs[2] = a2; addrs[3] = a3;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("b2b_ready", bus.cpu_ready_o, 1);
            bus.cpu_req_i  = 1'b1;
            bus.cpu_we_i   = 1'b0;
            bus.cpu_addr_i = addrs[k];
            @(negedge clk);
            check("b2b_rv", bus.cpu_rvalid_o, 1);
            check("b2b_data", bus.cpu_rdata_o, mem_read(addrs[k]));
            check("b2b_noreq", bus.mem_req_o, 0);
            promote(addrs[k], find(addrs[k]));
            exp_hits++;
        end
        bus.cpu_req_i = 1'b0;
    endtask

    initial begin
        bus.cpu_req_i   = 1'b0;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_addr_i  = '0;
        bus.cpu_wdata_i = '0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        clear_model();

        repeat (2) @(negedge clk);
        check("rst_notready", bus.cpu_ready_o, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", bus.cpu_ready_o, 1);
        check("rst_rvalid", bus.cpu_rvalid_o, 0);
        check("rst_rdata", bus.cpu_rdata_o, 0);
        check("rst_mem_req", bus.mem_req_o, 0);
        check("rst_mem_we", bus.mem_we_o, 0);
        check("rst_mem_addr", bus.mem_addr_o, 0);
        check("rst_mem_wdata", bus.mem_wdata_o, 0);

        mem_model[32'h40] = 32'hDEAD_BEEF;
        do_load(32'h40, 3, "first_miss");
        check("first_data", bus.cpu_rdata_o, 32'hDEAD_BEEF);
        do_load(32'h40, 1, "first_rehit");

        do_load(32'h08, 2, "set2_t0");
        do_load(32'h28, 1, "set2_t1");
        do_load(32'h48, 4, "set2_t2");
        do_load(32'h68, 2, "set2_t3");
        do_load(32'h08, 1, "set2_reload");
        do_load(32'h88, 2, "set2_evict");
        do_load(32'h08, 1, "set2_kept");

        do_store(32'h48, 32'h1234_5678, 2, "st_hit");
        do_load(32'h48, 1, "st_hit_reload");
        check("st_hit_value", bus.cpu_rdata_o, 32'h1234_5678);
        do_load(32'h28, 3, "set2_evicted");
        do_store(32'h100, 32'hCAFE_0100, 1, "st_miss");
        do_load(32'h100, 2, "st_miss_reload");

        reset_mid_miss(32'h200);
        do_load(32'h200, 2, "after_rst");
        do_load(32'h204, 1, "fill_a");
        do_load(32'h208, 1, "fill_b");
        do_load(32'h20C, 1, "fill_c");
        back_to_back(32'h200, 32'h204, 32'h208, 32'h20C);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 5)) << 5) | (32'($urandom_range(0, 3)) << 2) |
                32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) do_store(a, $urandom, $urandom_range(1, 4), "rnd_st");
            else do_load(a, $urandom_range(1, 4), "rnd_ld");
        end

`ifdef CACHE_STATS_EN
        @(negedge clk);
        check("stat_hits", stat_hits, exp_hits);
        check("stat_misses", stat_misses, exp_misses);
        check("stat_writes", stat_writes, exp_writes);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
